unidad_acceso_memoria: RTL

//  Load/store unit between the core and data memory; produces datoMem for the writeback mux (Senal=2'b10).

---
 rtl/unidad_acceso_memoria_if.sv | 21 ++
 rtl/unidad_acceso_memoria.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/unidad_acceso_memoria_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// mem_req is held until the one-cycle mem_ack; mem_rdata is valid with mem_ack.
interface unidad_acceso_memoria_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/unidad_acceso_memoria.sv
// Load/store unit: aligns/strobes stores, extends loads, req/ack with timeout; optional MISALIGN_TRAP_EN.
// Inicio->Listo >= 2 cycles (ack@k -> Listo@k+1); one access in flight, Inicio ignored while Ocupado.
module unidad_acceso_memoria #(
  parameter int TIMEOUT_CICLOS = 16,
  parameter int ANCHO_CONT     = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Inicio,
  input  logic                           EsCarga,
  input  logic [2:0]                     Funct3,
  input  logic [31:0]                    Direccion,
  input  logic [31:0]                    DatoEscritura,
  unidad_acceso_memoria_if.master        mem,
  output logic [31:0]                    datoMem,
  output logic                           Listo,
  output logic                           Ocupado,
`ifdef MISALIGN_TRAP_EN
  output logic                           ErrorAlin,
`endif
  output logic                           ErrorBus
);

  typedef enum logic [1:0] {REPOSO, SOLICITUD, ESPERA, FIN} estado_t;

  localparam logic [ANCHO_CONT-1:0] CNT_MAX = ANCHO_CONT'(TIMEOUT_CICLOS - 1);

  estado_t               estado;
  logic [ANCHO_CONT-1:0] cnt;
  logic [2:0]            f3_q;
  logic [1:0]            dir_lo;
  logic                  carga_q;

  function automatic logic [3:0] strobe(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   strobe = 4'b0001 << a;
      2'b01:   strobe = a[1] ? 4'b1100 : 4'b0011;
      default: strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replica(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   replica = {4{d[7:0]}};
      2'b01:   replica = {2{d[15:0]}};
      default: replica = d;
    endcase
  endfunction

  // Picks the addressed lane out of the word, then sign- or zero-extends it.
  function automatic logic [31:0] extrae(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   extrae = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   extrae = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: extrae = w;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic desalineado(input logic [2:0] f3, input logic [1:0] a);
    desalineado = ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a != 2'b00));
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      estado        <= REPOSO;
      cnt           <= '0;
      f3_q          <= 3'b000;
      dir_lo        <= 2'b00;
      carga_q       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wdata <= 32'h0;
      mem.mem_wstrb <= 4'b0000;
      datoMem       <= 32'h0;
      Listo         <= 1'b0;
      Ocupado       <= 1'b0;
      ErrorBus      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      ErrorAlin     <= 1'b0;
`endif
    end else begin
      Listo <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      ErrorAlin <= 1'b0;
`endif
      case (estado)
        REPOSO: begin
          if (Inicio) begin
            f3_q    <= Funct3;
            dir_lo  <= Direccion[1:0];
            carga_q <= EsCarga;
            cnt     <= '0;
            Ocupado <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            if (desalineado(Funct3, Direccion[1:0])) begin
              estado    <= FIN;
              Listo     <= 1'b1;
              ErrorAlin <= 1'b1;
            end else
`endif
            begin
              estado        <= SOLICITUD;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= ~EsCarga;
              mem.mem_addr  <= {Direccion[31:2], 2'b00};
              mem.mem_wdata <= EsCarga ? 32'h0 : replica(Funct3, DatoEscritura);
              mem.mem_wstrb <= EsCarga ? 4'b0000 : strobe(Funct3, Direccion[1:0]);
            end
          end
        end
        SOLICITUD, ESPERA: begin
          // An ack arriving on the last allowed cycle still completes normally.
          if (mem.mem_ack || (cnt == CNT_MAX)) begin
            estado        <= FIN;
            Listo         <= 1'b1;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wdata <= 32'h0;
            mem.mem_wstrb <= 4'b0000;
            if (mem.mem_ack) begin
              if (carga_q) datoMem <= extrae(f3_q, dir_lo, mem.mem_rdata);
            end else begin
              ErrorBus <= 1'b1;
              datoMem  <= 32'h0;
            end
          end else begin
            cnt    <= cnt + 1'b1;
            estado <= ESPERA;
          end
        end
        FIN: begin
          estado  <= REPOSO;
          Ocupado <= 1'b0;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule
